// File: rtl/lc3_mem_arbiter.sv
// Two-requester arbiter for the single-port LC-3 main memory: CPU has priority,
// debug is forced through after STARVE_LIMIT CPU grants while it waits.
//   state  | meaning
//   IDLE   | no access in flight; arbitrate eligible requesters
//   BUSY   | access in flight; mem_en held for MEM_LATENCY cycles
module lc3_mem_arbiter #(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ready,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [15:0] dbg_addr,
    input  logic [15:0] dbg_wdata,
    output logic [15:0] dbg_rdata,
    output logic        dbg_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        owner
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    localparam logic [3:0] LAT_LAST   = 4'(MEM_LATENCY - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [3:0]  lat_cnt_q, lat_cnt_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0] dbg_rdata_q, dbg_rdata_d;
    logic        cpu_ready_q, cpu_ready_d;
    logic        dbg_ready_q, dbg_ready_d;

    logic cpu_elig;
    logic dbg_elig;
    logic grant_dbg;

    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        cpu_ready_d  = 1'b0;
        dbg_ready_d  = 1'b0;

        // A requester still high during its own ready cycle is the finished access, not a new one.
        cpu_elig  = cpu_req & ~cpu_ready_q;
        dbg_elig  = dbg_req & ~dbg_ready_q;
        grant_dbg = dbg_elig & (~cpu_elig | (starve_cnt_q == STARVE_MAX));

        case (state_q)
            S_IDLE: begin
                if (cpu_elig || dbg_elig) begin
                    state_d   = S_BUSY;
                    lat_cnt_d = 4'd0;
                    owner_d   = grant_dbg;
                    we_d      = grant_dbg ? dbg_we    : cpu_we;
                    addr_d    = grant_dbg ? dbg_addr  : cpu_addr;
                    wdata_d   = grant_dbg ? dbg_wdata : cpu_wdata;
                    if (!grant_dbg && dbg_req) begin
                        starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? STARVE_MAX
                                                                    : starve_cnt_q + 4'd1;
                    end else begin
                        starve_cnt_d = 4'd0;
                    end
                end
            end
            S_BUSY: begin
                lat_cnt_d = lat_cnt_q + 4'd1;
                if (lat_cnt_q == LAT_LAST) begin
                    state_d = S_IDLE;
                    if (owner_q) begin
                        dbg_ready_d = 1'b1;
                        if (!we_q) dbg_rdata_d = mem_rdata;
                    end else begin
                        cpu_ready_d = 1'b1;
                        if (!we_q) cpu_rdata_d = mem_rdata;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            lat_cnt_q    <= 4'd0;
            starve_cnt_q <= 4'd0;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 16'h0;
            wdata_q      <= 16'h0;
            cpu_rdata_q  <= 16'h0;
            dbg_rdata_q  <= 16'h0;
            cpu_ready_q  <= 1'b0;
            dbg_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
            cpu_ready_q  <= cpu_ready_d;
            dbg_ready_q  <= dbg_ready_d;
        end
    end

    assign busy      = (state_q == S_BUSY);
    assign owner     = owner_q;
    assign mem_en    = busy;
    assign mem_we    = busy & we_q;
    assign mem_addr  = busy ? addr_q  : 16'h0;
    assign mem_wdata = busy ? wdata_q : 16'h0;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign dbg_rdata = dbg_rdata_q;
    assign dbg_ready = dbg_ready_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter: one instance at MEM_LATENCY=2 against a
// memory array, one at MEM_LATENCY=1 against an address-derived read pattern.
module tb_lc3_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [15:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_ready, dbg_ready, mem_en, mem_we, busy, owner;

    logic        cpu_req_1, cpu_we_1, dbg_req_1, dbg_we_1;
    logic [15:0] cpu_addr_1, cpu_wdata_1, dbg_addr_1, dbg_wdata_1;
    logic [15:0] cpu_rdata_1, dbg_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;
    logic        cpu_ready_1, dbg_ready_1, mem_en_1, mem_we_1, busy_1, owner_1;

    logic [15:0] mem [0:65535];

    assign mem_rdata = mem_en ? mem[mem_addr] : 16'h0;
    always @(posedge clk) if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;

    assign mem_rdata_1 = mem_en_1 ? (mem_addr_1 ^ 16'h5A5A) : 16'h0;

    lc3_mem_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(4)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    lc3_mem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) u_dut_1 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req_1), .cpu_we(cpu_we_1), .cpu_addr(cpu_addr_1), .cpu_wdata(cpu_wdata_1),
        .cpu_rdata(cpu_rdata_1), .cpu_ready(cpu_ready_1),
        .dbg_req(dbg_req_1), .dbg_we(dbg_we_1), .dbg_addr(dbg_addr_1), .dbg_wdata(dbg_wdata_1),
        .dbg_rdata(dbg_rdata_1), .dbg_ready(dbg_ready_1),
        .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
        .mem_rdata(mem_rdata_1), .busy(busy_1), .owner(owner_1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    logic [9:0] exp_own;
    int         n_grant;
    logic       prev_busy, prev_cready;

    initial begin
        rst = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 16'h0; dbg_wdata = 16'h0;
        cpu_req_1 = 1'b0; cpu_we_1 = 1'b0; cpu_addr_1 = 16'h0; cpu_wdata_1 = 16'h0;
        dbg_req_1 = 1'b0; dbg_we_1 = 1'b0; dbg_addr_1 = 16'h0; dbg_wdata_1 = 16'h0;
        mem[16'h3000] = 16'h1234;
        mem[16'h5000] = 16'hC0DE;
        repeat (3) nxt();

        check("rst_busy",      16'(busy),      16'd0);
        check("rst_mem_en",    16'(mem_en),    16'd0);
        check("rst_owner",     16'(owner),     16'd0);
        check("rst_cpu_ready", 16'(cpu_ready), 16'd0);
        check("rst_cpu_rdata", cpu_rdata,      16'h0000);
        check("rst_dbg_rdata", dbg_rdata,      16'h0000);
        check("rst_mem_addr",  mem_addr,       16'h0000);
        rst = 1'b1;
        nxt();

        // single CPU read of 3000
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
        nxt();
        check("rd_en_c1",     16'(mem_en), 16'd1);
        check("rd_addr_c1",   mem_addr,    16'h3000);
        check("rd_we_c1",     16'(mem_we), 16'd0);
        check("rd_owner_c1",  16'(owner),  16'd0);
        nxt();
        check("rd_en_c2",     16'(mem_en),    16'd1);
        check("rd_ready_c2",  16'(cpu_ready), 16'd0);
        nxt();
        check("rd_en_c3",     16'(mem_en),    16'd0);
        check("rd_ready_c3",  16'(cpu_ready), 16'd1);
        check("rd_rdata_c3",  cpu_rdata,      16'h1234);
        check("rd_dbgrdy_c3", 16'(dbg_ready), 16'd0);
        cpu_req = 1'b0;
        nxt();
        check("rd_ready_c4",  16'(cpu_ready), 16'd0);
        check("rd_hold_c4",   cpu_rdata,      16'h1234);

        // debug write BEEF to 4000, then CPU read of 4000 granted in the debug ready cycle
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h4000; dbg_wdata = 16'hBEEF;
        nxt();
        check("dw_we_c1",    16'(mem_we), 16'd1);
        check("dw_owner_c1", 16'(owner),  16'd1);
        check("dw_addr_c1",  mem_addr,    16'h4000);
        check("dw_wdata_c1", mem_wdata,   16'hBEEF);
        nxt();
        check("dw_we_c2",    16'(mem_we), 16'd1);
        nxt();
        check("dw_ready_c3", 16'(dbg_ready), 16'd1);
        check("dw_en_c3",    16'(mem_en),    16'd0);
        check("dw_we_c3",    16'(mem_we),    16'd0);
        check("dw_rdata_c3", dbg_rdata,      16'h0000);
        check("dw_cpurdy_c3", 16'(cpu_ready), 16'd0);
        dbg_req = 1'b0; dbg_we = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4000;
        nxt();
        check("cr_en_c1",    16'(mem_en), 16'd1);
        check("cr_we_c1",    16'(mem_we), 16'd0);
        check("cr_owner_c1", 16'(owner),  16'd0);
        nxt();
        nxt();
        check("cr_ready",    16'(cpu_ready), 16'd1);
        check("cr_rdata",    cpu_rdata,      16'hBEEF);
        check("cr_dbgrdata", dbg_rdata,      16'h0000);
        check("cr_dbgready", 16'(dbg_ready), 16'd0);
        cpu_req = 1'b0;
        nxt();

        // CPU request raised while a debug read is in flight
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h3000;
        nxt();
        check("mf_owner_c1", 16'(owner), 16'd1);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h5000;
        nxt();
        check("mf_owner_c2", 16'(owner), 16'd1);
        check("mf_addr_c2",  mem_addr,   16'h3000);
        nxt();
        check("mf_dbgready", 16'(dbg_ready), 16'd1);
        check("mf_dbgrdata", dbg_rdata,      16'h1234);
        check("mf_gap_en",   16'(mem_en),    16'd0);
        check("mf_cpurdata", cpu_rdata,      16'hBEEF);
        dbg_req = 1'b0;
        nxt();
        check("mf_cpu_en",    16'(mem_en), 16'd1);
        check("mf_cpu_owner", 16'(owner),  16'd0);
        check("mf_cpu_addr",  mem_addr,    16'h5000);
        nxt();
        nxt();
        check("mf_cpuready", 16'(cpu_ready), 16'd1);
        check("mf_cpurdata2", cpu_rdata,     16'hC0DE);
        check("mf_dbghold",  dbg_rdata,      16'h1234);
        cpu_req = 1'b0;
        nxt();

        // reset in the second BUSY cycle of a CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
        nxt();
        check("rs_busy_c1", 16'(busy), 16'd1);
        nxt();
        rst = 1'b0;
        nxt();
        check("rs_busy",   16'(busy),      16'd0);
        check("rs_en",     16'(mem_en),    16'd0);
        check("rs_ready",  16'(cpu_ready), 16'd0);
        check("rs_rdata",  cpu_rdata,      16'h0000);
        check("rs_drdata", dbg_rdata,      16'h0000);
        rst = 1'b1;
        nxt();
        check("rs_re_en",    16'(mem_en),    16'd1);
        check("rs_re_ready", 16'(cpu_ready), 16'd0);
        nxt();
        nxt();
        check("rs_re_done",  16'(cpu_ready), 16'd1);
        check("rs_re_rdata", cpu_rdata,      16'h1234);
        cpu_req = 1'b0;
        nxt();
        nxt();

        // starvation limit: CPU holds req; debug holds req except in CPU ready cycles
        exp_own = 10'b10_0001_0000;
        n_grant = 0;
        prev_busy = 1'b0;
        prev_cready = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h4000;
        for (int c = 0; c < 200 && n_grant < 10; c++) begin
            nxt();
            if (prev_cready) check("no_regrant", 16'(busy), 16'd0);
            if (busy && !prev_busy) begin
                check($sformatf("grant%0d_owner", n_grant), 16'(owner), 16'(exp_own[n_grant]));
                n_grant++;
            end
            prev_busy   = busy;
            prev_cready = cpu_ready;
            dbg_req     = !cpu_ready;
        end
        check("starve_grants", 16'(n_grant), 16'd10);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        repeat (6) nxt();

        // MEM_LATENCY=1: one-cycle access, completions every two cycles across requesters
        cpu_req_1 = 1'b1; cpu_addr_1 = 16'h0010;
        dbg_req_1 = 1'b1; dbg_addr_1 = 16'h0020;
        nxt();
        check("l1_en_c1",    16'(mem_en_1), 16'd1);
        check("l1_owner_c1", 16'(owner_1),  16'd0);
        check("l1_addr_c1",  mem_addr_1,    16'h0010);
        nxt();
        check("l1_en_c2",    16'(mem_en_1),    16'd0);
        check("l1_cready_c2", 16'(cpu_ready_1), 16'd1);
        check("l1_crdata_c2", cpu_rdata_1,      16'h5A4A);
        nxt();
        check("l1_en_c3",    16'(mem_en_1), 16'd1);
        check("l1_owner_c3", 16'(owner_1),  16'd1);
        nxt();
        check("l1_dready_c4", 16'(dbg_ready_1), 16'd1);
        check("l1_drdata_c4", dbg_rdata_1,      16'h5A7A);
        check("l1_en_c4",     16'(mem_en_1),    16'd0);
        nxt();
        check("l1_en_c5",    16'(mem_en_1), 16'd1);
        check("l1_owner_c5", 16'(owner_1),  16'd0);
        nxt();
        check("l1_cready_c6", 16'(cpu_ready_1), 16'd1);
        cpu_req_1 = 1'b0;
        dbg_req_1 = 1'b0;
        nxt();
        check("l1_idle_c7", 16'(busy_1), 16'd0);
        repeat (2) nxt();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
